logu_seq: RTL and testbench

Bit-serial sequencer and two-port arbiter for the 1-bit logic unit (`LogU`). Two requesters submit W-bit operand pairs with a 3-bit opcode. The block grants one requester round-robin and streams the operands LSB-first through the logic unit, one bit per cycle. It then assembles the W-bit result and returns it on a valid/ready response channel tagged with the requester id.

---
 rtl/logu_seq.sv | 136 +++++++++++++
 tb/tb_logu_seq.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logu_seq.sv
// logu_seq: round-robin two-port arbiter and bit-serial sequencer for the
// 1-bit logic unit. Operands are streamed LSB-first. The assembled result
// is returned on a valid/ready channel, tagged with the owning requester id.
module logu_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         r0_valid,
  output logic         r0_ready,
  input  logic [2:0]   r0_op,
  input  logic [W-1:0] r0_a,
  input  logic [W-1:0] r0_b,
  input  logic         r1_valid,
  output logic         r1_ready,
  input  logic [2:0]   r1_op,
  input  logic [W-1:0] r1_a,
  input  logic [W-1:0] r1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_data,
  output logic         rsp_err,
  output logic         lu_a,
  output logic         lu_b,
  output logic         lu_opsel0,
  output logic         lu_opsel1,
  output logic         lu_opsel2,
  input  logic         lu_out,
  output logic         busy
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic           last;
  logic [CW-1:0]  cnt;
  logic [2:0]     op_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   res_q;
  logic           id_q;
  logic           err_q;

  logic           g0;
  logic           g1;
  logic           acc;
  logic           sel_id;
  logic [2:0]     sel_op;
  logic [W-1:0]   sel_a;
  logic [W-1:0]   sel_b;
  logic           run;

  // Opcodes 000..100 are implemented by the logic unit; 101..111 are rejected.
  function automatic logic op_legal(input logic [2:0] op);
    return (op <= 3'd4);
  endfunction

  // Round-robin grant: a lone requester wins, a tie goes to the one that was not served last.
  always_comb begin
    g0       = r0_valid & (~r1_valid | last);
    g1       = r1_valid & (~r0_valid | ~last);
    r0_ready = (state == IDLE) & g0;
    r1_ready = (state == IDLE) & g1;
    acc      = r0_ready | r1_ready;
    sel_id   = r1_ready;
    sel_op   = r1_ready ? r1_op : r0_op;
    sel_a    = r1_ready ? r1_a  : r0_a;
    sel_b    = r1_ready ? r1_b  : r0_b;
  end

  // Operand capture on acceptance; requester inputs are free to change afterwards.
  always_ff @(posedge clk) begin
    if (acc) begin
      op_q <= sel_op;
      a_q  <= sel_a;
      b_q  <= sel_b;
    end
  end

  // Sequencer FSM: accept in IDLE, one result bit per RUN cycle, hold the response in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
      id_q  <= 1'b0;
      err_q <= 1'b0;
      res_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (acc) begin
            id_q  <= sel_id;
            last  <= sel_id;
            cnt   <= '0;
            res_q <= '0;
            err_q <= ~op_legal(sel_op);
            state <= op_legal(sel_op) ? RUN : DONE;
          end
        end
        RUN: begin
          res_q[cnt] <= lu_out;
          cnt        <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Logic-unit drive is gated to RUN so the unit sees AND select and zero operands otherwise.
  always_comb begin
    run       = (state == RUN);
    lu_a      = run & a_q[cnt];
    lu_b      = run & b_q[cnt];
    lu_opsel0 = run & op_q[0];
    lu_opsel1 = run & op_q[1];
    lu_opsel2 = run & op_q[2];
    rsp_valid = (state == DONE);
    busy      = (state != IDLE);
    rsp_data  = res_q;
    rsp_id    = id_q;
    rsp_err   = err_q;
  end

endmodule

// File: tb/tb_logu_seq.sv
// tb_logu_seq: scoreboard bench for logu_seq with a behavioural logic-unit
// model; a second W=1 instance covers the single-bit build.
module tb_logu_seq;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         r0_valid, r0_ready, r1_valid, r1_ready;
  logic [2:0]   r0_op, r1_op;
  logic [W-1:0] r0_a, r0_b, r1_a, r1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [W-1:0] rsp_data;
  logic         lu_a, lu_b, lu_opsel0, lu_opsel1, lu_opsel2, lu_out, busy;

  logic         x_valid, x_ready, x_r1_ready, x_rsp_valid, x_rsp_ready, x_rsp_id, x_rsp_err;
  logic         x_lu_a, x_lu_b, x_s0, x_s1, x_s2, x_lu_out, x_busy;
  logic [2:0]   x_op;
  logic [0:0]   x_a, x_b, x_rsp_data;

  logu_seq #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .lu_a(lu_a), .lu_b(lu_b), .lu_opsel0(lu_opsel0),
    .lu_opsel1(lu_opsel1), .lu_opsel2(lu_opsel2), .lu_out(lu_out), .busy(busy)
  );

  logu_seq #(.W(1)) dut1 (
    .clk(clk), .rst(rst),
    .r0_valid(x_valid), .r0_ready(x_ready), .r0_op(x_op), .r0_a(x_a), .r0_b(x_b),
    .r1_valid(1'b0), .r1_ready(x_r1_ready), .r1_op(3'b000), .r1_a(1'b0), .r1_b(1'b0),
    .rsp_valid(x_rsp_valid), .rsp_ready(x_rsp_ready), .rsp_id(x_rsp_id), .rsp_data(x_rsp_data),
    .rsp_err(x_rsp_err), .lu_a(x_lu_a), .lu_b(x_lu_b), .lu_opsel0(x_s0),
    .lu_opsel1(x_s1), .lu_opsel2(x_s2), .lu_out(x_lu_out), .busy(x_busy)
  );

  // Behavioural 1-bit logic unit; SHL emits the previous a bit (0 on the first bit).
  function automatic logic lu_f(input logic [2:0] op, input logic a, input logic b, input logic s);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~a;
      3'd4:    return s;
      default: return 1'b0;
    endcase
  endfunction

  logic shl_q;
  always @(posedge clk) shl_q <= ({lu_opsel2, lu_opsel1, lu_opsel0} == 3'd4) ? lu_a : 1'b0;
  assign lu_out   = lu_f({lu_opsel2, lu_opsel1, lu_opsel0}, lu_a, lu_b, shl_q);
  assign x_lu_out = lu_f({x_s2, x_s1, x_s0}, x_lu_a, x_lu_b, 1'b0);

  // Word-level reference result.
  function automatic logic [W-1:0] ref_res(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~a;
      3'd4:    return a << 1;
      default: return '0;
    endcase
  endfunction

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic         id;
    logic [W-1:0] data;
    logic         err;
    int           due;
  } exp_t;

  exp_t         q[$];
  exp_t         e;
  int           acc_cyc[$];
  int           cyc = 0;
  int           nacc = 0;
  int           nrsp = 0;
  logic         last_m = 1'b1;
  logic [2:0]   cur_op, osel, a_op;
  logic [W-1:0] cur_a, cur_b, a_a, a_b;
  logic         a_id, seen = 1'b0;
  int           bitn = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: arbitration model, RUN drive checks, scoreboard push on accept and pop on response.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      last_m = 1'b1;
      seen   = 1'b0;
    end else begin
      osel = {lu_opsel2, lu_opsel1, lu_opsel0};
      check("one_ready", r0_ready & r1_ready, 0);
      check("r0_ready", r0_ready, !busy && r0_valid && (!r1_valid || last_m));
      check("r1_ready", r1_ready, !busy && r1_valid && (!r0_valid || !last_m));
      if (busy && !rsp_valid) begin
        if (bitn < W) begin
          check("lu_op", osel, cur_op);
          check("lu_a", lu_a, cur_a[bitn]);
          check("lu_b", lu_b, cur_b[bitn]);
        end else begin
          check("run_len", bitn, W - 1);
        end
        bitn++;
      end else begin
        check("lu_idle", {lu_a, lu_b, osel}, 0);
      end
      if (rsp_valid) begin
        if (q.size() == 0) begin
          check("spurious_rsp", 1, 0);
        end else begin
          if (!seen) begin
            check("latency", cyc, q[0].due);
            seen = 1'b1;
          end
          if (rsp_ready) begin
            check("rsp_id", rsp_id, q[0].id);
            check("rsp_data", rsp_data, q[0].data);
            check("rsp_err", rsp_err, q[0].err);
            void'(q.pop_front());
            seen = 1'b0;
            nrsp++;
          end
        end
      end
      if ((r0_valid && r0_ready) || (r1_valid && r1_ready)) begin
        a_id = r1_ready;
        a_op = a_id ? r1_op : r0_op;
        a_a  = a_id ? r1_a : r0_a;
        a_b  = a_id ? r1_b : r0_b;
        e.id   = a_id;
        e.err  = (a_op > 3'd4);
        e.data = e.err ? '0 : ref_res(a_op, a_a, a_b);
        e.due  = cyc + (e.err ? 1 : W + 1);
        q.push_back(e);
        cur_op = a_op;
        cur_a  = a_a;
        cur_b  = a_b;
        bitn   = 0;
        last_m = a_id;
        nacc++;
        acc_cyc.push_back(cyc);
      end
    end
  end

  task automatic send(input logic id, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int k;
    if (id) begin
      r1_op = op; r1_a = a; r1_b = b; r1_valid = 1'b1;
    end else begin
      r0_op = op; r0_a = a; r0_b = b; r0_valid = 1'b1;
    end
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(id ? r1_ready : r0_ready) && k < 100);
    if (!(id ? r1_ready : r0_ready)) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    r0_valid = 1'b0;
    r1_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    int k;
    k = 0;
    while (nrsp < n && k < 300) begin
      @(posedge clk);
      k++;
    end
    if (nrsp < n) check("rsp_timeout", nrsp, n);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] hold_d;
  logic         hold_id;
  int           n0, k, tgt;

  initial begin
    rst = 1'b1;
    r0_valid = 1'b0; r1_valid = 1'b0; r0_op = '0; r1_op = '0;
    r0_a = '0; r0_b = '0; r1_a = '0; r1_b = '0; rsp_ready = 1'b1;
    x_valid = 1'b0; x_op = '0; x_a = '0; x_b = '0; x_rsp_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_busy", busy, 0);
    check("rst_lu", {lu_a, lu_b, lu_opsel2, lu_opsel1, lu_opsel0}, 0);
    check("rst_ready", {r0_ready, r1_ready}, 0);
    check("rst_x", {x_busy, x_rsp_valid, x_rsp_id, x_r1_ready}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // r0 alone, AND
    r0_op = 3'd0; r0_a = 8'hF0; r0_b = 8'h3C; r0_valid = 1'b1;
    @(negedge clk);
    check("t1_ready", r0_ready, 1);
    @(posedge clk); #1;
    r0_valid = 1'b0;
    wait_rsp(1);

    // Both valid continuously after a fresh reset: 0,1,0,1 at a W+2 period
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    n0 = nacc;
    r0_op = 3'd2; r0_a = 8'hAA; r0_b = 8'hFF;
    r1_op = 3'd3; r1_a = 8'h0F; r1_b = 8'h33;
    r0_valid = 1'b1; r1_valid = 1'b1;
    k = 0;
    while (nacc < n0 + 4 && k < 200) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk); #1;
    r0_valid = 1'b0; r1_valid = 1'b0;
    if (nacc < n0 + 4) check("alt_accepts", nacc - n0, 4);
    wait_rsp(5);
    for (int i = 1; i < 4; i++) begin
      if (n0 + i < acc_cyc.size()) check("alt_period", acc_cyc[n0 + i] - acc_cyc[n0 + i - 1], W + 2);
    end

    // Illegal opcode from r1
    send(1'b1, 3'd6, 8'h5A, 8'hA5);
    wait_rsp(6);

    // Back-pressure: response held while both requesters keep asking
    rsp_ready = 1'b0;
    send(1'b0, 3'd2, 8'h12, 8'h34);
    r0_valid = 1'b1; r1_valid = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rsp_valid && k < 50);
    check("bp_valid", rsp_valid, 1);
    hold_d  = rsp_data;
    hold_id = rsp_id;
    check("bp_data", hold_d, 8'h26);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_data_stable", rsp_data, hold_d);
      check("bp_id_stable", rsp_id, hold_id);
      check("bp_busy", busy, 1);
      check("bp_readies", {r0_ready, r1_ready}, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1; r0_valid = 1'b0; r1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("bp_idle_busy", busy, 0);
    check("bp_idle_valid", rsp_valid, 0);

    // SHL and a handful of random requests, including illegal codes
    tgt = nrsp + 1;
    send(1'b0, 3'd4, 8'h81, 8'h00);
    wait_rsp(tgt);
    for (int i = 0; i < 6; i++) begin
      tgt = nrsp + 1;
      send(1'($urandom_range(0, 1)), 3'($urandom_range(0, 5)), 8'($urandom), 8'($urandom));
      wait_rsp(tgt);
    end

    // Reset during bit 3 of an OR request
    send(1'b0, 3'd1, 8'h0F, 8'h30);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    r0_op = 3'd1; r0_a = 8'h0F; r0_b = 8'h30;
    r1_op = 3'd0; r1_a = 8'hFF; r1_b = 8'hFF;
    r0_valid = 1'b1; r1_valid = 1'b1;
    @(negedge clk);
    check("rr_busy", busy, 0);
    check("rr_rsp_valid", rsp_valid, 0);
    check("rr_lu", {lu_a, lu_b, lu_opsel2, lu_opsel1, lu_opsel0}, 0);
    check("rr_grant", {r1_ready, r0_ready}, 2'b01);
    tgt = nrsp + 1;
    @(posedge clk); #1;
    r0_valid = 1'b0; r1_valid = 1'b0;
    wait_rsp(tgt);

    // W=1 build: OR of 0 and 1
    x_op = 3'd1; x_a = 1'b0; x_b = 1'b1; x_valid = 1'b1;
    @(negedge clk);
    check("w1_ready", x_ready, 1);
    @(posedge clk); #1;
    x_valid = 1'b0;
    @(negedge clk);
    check("w1_run", {x_busy, x_rsp_valid}, 2'b10);
    check("w1_lu", {x_lu_a, x_lu_b, x_s2, x_s1, x_s0}, 5'b01001);
    @(negedge clk);
    check("w1_rsp_valid", x_rsp_valid, 1);
    check("w1_rsp_data", x_rsp_data, 1);
    check("w1_rsp_err_id", {x_rsp_err, x_rsp_id}, 0);
    @(negedge clk);
    check("w1_idle", x_busy, 0);

    repeat (3) @(posedge clk);
    check("sb_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
